// File: rtl/mcore_mem_arbiter_if.sv
// Per-master request/response bus plus the shared downstream memory port of the mcore arbiter.
// A request is accepted in the cycle where req and gnt are both high. The requester holds
// req/addr/we/wdata/be stable until that cycle. Each accepted request (read or write) returns
// exactly one rsp_valid strobe, in acceptance order. Responses cannot be stalled.
interface mcore_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]                s_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0]     s_addr;
  logic [NUM_REQ-1:0]                s_we;
  logic [NUM_REQ*DATA_WIDTH-1:0]     s_wdata;
  logic [NUM_REQ*DATA_WIDTH/8-1:0]   s_be;
  logic [NUM_REQ-1:0]                s_gnt;
  logic [NUM_REQ-1:0]                s_rsp_valid;
  logic [DATA_WIDTH-1:0]             s_rsp_rdata;
  logic                              s_rsp_error;

  logic                              mem_req;
  logic [ADDR_WIDTH-1:0]             mem_addr;
  logic                              mem_we;
  logic [DATA_WIDTH-1:0]             mem_wdata;
  logic [DATA_WIDTH/8-1:0]           mem_be;
  logic                              mem_gnt;
  logic                              mem_rsp_valid;
  logic [DATA_WIDTH-1:0]             mem_rsp_rdata;
  logic                              mem_rsp_error;

  // Arbiter view: serves the internal masters and drives the memory port.
  modport slave (
    input  s_req, s_addr, s_we, s_wdata, s_be,
    output s_gnt, s_rsp_valid, s_rsp_rdata, s_rsp_error,
    output mem_req, mem_addr, mem_we, mem_wdata, mem_be,
    input  mem_gnt, mem_rsp_valid, mem_rsp_rdata, mem_rsp_error
  );

  // Environment view: the internal masters together with the external memory.
  modport master (
    output s_req, s_addr, s_we, s_wdata, s_be,
    input  s_gnt, s_rsp_valid, s_rsp_rdata, s_rsp_error,
    input  mem_req, mem_addr, mem_we, mem_wdata, mem_be,
    output mem_gnt, mem_rsp_valid, mem_rsp_rdata, mem_rsp_error
  );
endinterface

// File: rtl/mcore_mem_arbiter.sv
// Round-robin arbiter sharing the mcore external memory port between NUM_REQ masters.
// In-flight master IDs are queued so that in-order responses can be steered back to their issuer.
module mcore_mem_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  mcore_mem_arbiter_if.slave                   bus,
  output logic                                 proto_err,
  output logic                                 dbg_state,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] dbg_count
);

  localparam int BW  = DATA_WIDTH / 8;
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE, LOCKED} lock_state_t;

  lock_state_t           lock_q, lock_d;
  logic [IDW-1:0]        rr_ptr_q;
  logic [IDW-1:0]        lock_sel_q;
  logic [IDW-1:0]        rr_sel;
  logic                  rr_found;
  logic [IDW-1:0]        sel;
  logic                  req_any;
  logic                  mem_req_w;
  logic                  handshake;

  logic [ADDR_WIDTH-1:0] mem_addr_w;
  logic                  mem_we_w;
  logic [DATA_WIDTH-1:0] mem_wdata_w;
  logic [BW-1:0]         mem_be_w;
  logic [NUM_REQ-1:0]    gnt_w;
  logic [NUM_REQ-1:0]    rspv_w;

  logic [IDW-1:0]        id_fifo [MAX_OUTSTANDING];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  full, empty;
  logic                  push, pop;
  logic [IDW-1:0]        head_id;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // First asserted request at or after the round-robin pointer, wrapping modulo NUM_REQ.
  always_comb begin : rr_search
    int             idx_int;
    logic [IDW-1:0] idx;
    rr_sel   = '0;
    rr_found = 1'b0;
    idx_int  = 0;
    idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_int = (int'(rr_ptr_q) + i) % NUM_REQ;
      idx     = IDW'(idx_int);
      if (!rr_found && bus.s_req[idx]) begin
        rr_found = 1'b1;
        rr_sel   = idx;
      end
    end
  end

  // A request offered but not yet granted keeps ownership of the port until it is accepted.
  assign sel       = (lock_q == LOCKED) ? lock_sel_q : rr_sel;
  assign req_any   = (lock_q == LOCKED) ? bus.s_req[lock_sel_q] : rr_found;
  assign full      = (count_q == CW'(MAX_OUTSTANDING));
  assign empty     = (count_q == '0);
  assign mem_req_w = req_any && !full;
  assign handshake = mem_req_w && bus.mem_gnt;
  assign push      = handshake;
  assign pop       = bus.mem_rsp_valid && !empty;
  assign head_id   = id_fifo[rd_ptr_q];

  always_comb begin : req_mux
    mem_addr_w  = '0;
    mem_we_w    = 1'b0;
    mem_wdata_w = '0;
    mem_be_w    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_any && (sel == IDW'(i))) begin
        mem_addr_w  = bus.s_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_we_w    = bus.s_we[i];
        mem_wdata_w = bus.s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        mem_be_w    = bus.s_be[i*BW +: BW];
      end
    end
  end

  always_comb begin : steer
    gnt_w  = '0;
    rspv_w = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_w[i]  = handshake && (sel == IDW'(i));
      rspv_w[i] = pop && (head_id == IDW'(i));
    end
  end

  assign bus.mem_req     = mem_req_w;
  assign bus.mem_addr    = mem_addr_w;
  assign bus.mem_we      = mem_we_w;
  assign bus.mem_wdata   = mem_wdata_w;
  assign bus.mem_be      = mem_be_w;
  assign bus.s_gnt       = gnt_w;
  assign bus.s_rsp_valid = rspv_w;
  assign bus.s_rsp_rdata = bus.mem_rsp_rdata;
  assign bus.s_rsp_error = bus.mem_rsp_error;

  always_comb begin : lock_next
    lock_d = lock_q;
    case (lock_q)
      IDLE:    if (mem_req_w && !bus.mem_gnt) lock_d = LOCKED;
      LOCKED:  if (handshake)                 lock_d = IDLE;
      default: lock_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lock_q     <= IDLE;
      lock_sel_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      lock_q <= lock_d;
      if (lock_q == IDLE && lock_d == LOCKED) lock_sel_q <= sel;
      if (handshake) rr_ptr_q <= (sel == IDW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (bus.mem_rsp_valid && empty) proto_err <= 1'b1;
    end
  end

  // ID storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge aclk) begin
    if (push) id_fifo[wr_ptr_q] <= sel;
  end

  assign dbg_state = (lock_q == LOCKED);
  assign dbg_count = count_q;

endmodule

// File: tb/tb_mcore_mem_arbiter.sv
// Directed bench for mcore_mem_arbiter: a queue-based reference model checked every cycle,
// plus hand-computed per-cycle expectations for the listed scenarios.
module tb_mcore_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 2;
  localparam int MO = 4;

  logic       aclk;
  logic       aresetn;
  logic       proto_err;
  logic       dbg_state;
  logic [2:0] dbg_count;

  mcore_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

  mcore_mem_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .MAX_OUTSTANDING(MO)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .bus       (bus),
    .proto_err (proto_err),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // ---------------- clock ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- counters / literal expectations ----------------
  int          n_cmp;
  int          n_fail;
  logic        lit_en;
  string       lit_name;
  logic [1:0]  lit_gnt, lit_rsp;
  logic        lit_req, lit_perr;
  logic [31:0] lit_addr;

  // ---------------- reference model state ----------------
  logic [7:0] exp_q[$];
  int         m_rr   = 0;
  int         m_pend = -1;
  bit         m_perr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected outputs from the current inputs and the in-flight queue.
  always @(negedge aclk) begin : compare
    int          c, rq;
    bit          want, full, e_req, hs;
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    logic [3:0]  e_be;
    logic [1:0]  e_gnt, e_rsp;
    if (!aresetn) begin
      exp_q.delete();
      m_rr   = 0;
      m_pend = -1;
      m_perr = 0;
      check("rst_mem_req",     64'(bus.mem_req),     64'd0);
      check("rst_s_gnt",       64'(bus.s_gnt),       64'd0);
      check("rst_s_rsp_valid", 64'(bus.s_rsp_valid), 64'd0);
      check("rst_proto_err",   64'(proto_err),       64'd0);
      check("rst_count",       64'(dbg_count),       64'd0);
    end else begin
      rq   = int'(bus.s_req);
      c    = 0;
      want = 0;
      if (m_pend >= 0) begin
        c    = m_pend;
        want = ((rq >> c) & 1) != 0;
      end else begin
        for (int k = 0; k < NR; k++) begin
          if (!want && ((rq >> ((m_rr + k) % NR)) & 1) != 0) begin
            want = 1;
            c    = (m_rr + k) % NR;
          end
        end
      end
      full    = (exp_q.size() == MO);
      e_req   = want && !full;
      e_addr  = want ? 32'(bus.s_addr >> (c * AW)) : 32'h0;
      e_wdata = want ? 32'(bus.s_wdata >> (c * DW)) : 32'h0;
      e_be    = want ? 4'(bus.s_be >> (c * 4)) : 4'h0;
      e_we    = want && (((int'(bus.s_we) >> c) & 1) != 0);
      hs      = e_req && bus.mem_gnt;
      e_gnt   = hs ? 2'(1 << c) : 2'b00;
      e_rsp   = (bus.mem_rsp_valid && exp_q.size() > 0) ? 2'(1 << exp_q[0]) : 2'b00;

      check("mem_req",     64'(bus.mem_req),     64'(e_req));
      check("mem_addr",    64'(bus.mem_addr),    64'(e_addr));
      check("mem_we",      64'(bus.mem_we),      64'(e_we));
      check("mem_wdata",   64'(bus.mem_wdata),   64'(e_wdata));
      check("mem_be",      64'(bus.mem_be),      64'(e_be));
      check("s_gnt",       64'(bus.s_gnt),       64'(e_gnt));
      check("s_rsp_valid", 64'(bus.s_rsp_valid), 64'(e_rsp));
      check("s_rsp_rdata", 64'(bus.s_rsp_rdata), 64'(bus.mem_rsp_rdata));
      check("s_rsp_error", 64'(bus.s_rsp_error), 64'(bus.mem_rsp_error));
      check("proto_err",   64'(proto_err),       64'(m_perr));
      check("count",       64'(dbg_count),       64'(exp_q.size()));
      check("lock_state",  64'(dbg_state),       64'(m_pend >= 0));

      if (lit_en) begin
        check({lit_name, "_gnt"},  64'(bus.s_gnt),       64'(lit_gnt));
        check({lit_name, "_rsp"},  64'(bus.s_rsp_valid), 64'(lit_rsp));
        check({lit_name, "_req"},  64'(bus.mem_req),     64'(lit_req));
        check({lit_name, "_addr"}, 64'(bus.mem_addr),    64'(lit_addr));
        check({lit_name, "_perr"}, 64'(proto_err),       64'(lit_perr));
      end

      if (bus.mem_rsp_valid) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        else m_perr = 1;
      end
      if (hs) begin
        exp_q.push_back(8'(c));
        m_rr   = (c + 1) % NR;
        m_pend = -1;
      end else if (e_req) begin
        m_pend = c;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic [1:0] req, input logic gnt, input logic rv,
                     input logic [31:0] rdata, input logic err);
    @(posedge aclk);
    #1;
    lit_en                = 1'b0;
    bus.s_req             = req;
    bus.mem_gnt           = gnt;
    bus.mem_rsp_valid     = rv;
    bus.mem_rsp_rdata     = rdata;
    bus.mem_rsp_error     = err;
  endtask

  task automatic expect_lit(input string name, input logic [1:0] g, input logic [1:0] r,
                            input logic q, input logic [31:0] a, input logic pe);
    lit_name = name;
    lit_gnt  = g;
    lit_rsp  = r;
    lit_req  = q;
    lit_addr = a;
    lit_perr = pe;
    lit_en   = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #1;
    lit_en            = 1'b0;
    aresetn           = 1'b0;
    bus.s_req         = '0;
    bus.mem_gnt       = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = '0;
    bus.mem_rsp_error = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    aresetn           = 1'b0;
    lit_en            = 1'b0;
    lit_name          = "";
    lit_gnt           = '0;
    lit_rsp           = '0;
    lit_req           = 1'b0;
    lit_addr          = '0;
    lit_perr          = 1'b0;
    bus.s_req         = '0;
    bus.s_addr        = '0;
    bus.s_we          = '0;
    bus.s_wdata       = '0;
    bus.s_be          = '0;
    bus.mem_gnt       = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = '0;
    bus.mem_rsp_error = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // 1: single read from master 0, response two cycles after the grant
    bus.s_addr = {32'h0000_3000, 32'h0027_1bd0};
    bus.s_be   = {4'hf, 4'hf};
    cyc(2'b01, 1, 0, 32'h0, 0); expect_lit("t1_grant", 2'b01, 2'b00, 1, 32'h0027_1bd0, 0);
    cyc(2'b00, 0, 0, 32'h0, 0); expect_lit("t1_wait",  2'b00, 2'b00, 0, 32'h0, 0);
    cyc(2'b00, 0, 1, 32'h5eed_0001, 0); expect_lit("t1_rsp", 2'b00, 2'b01, 0, 32'h0, 0);
    cyc(2'b00, 0, 0, 32'h0, 0);

    // 2: both masters requesting, grants alternate starting from master 0
    do_reset();
    bus.s_addr = {32'h0000_2000, 32'h0000_1000};
    cyc(2'b11, 1, 0, 32'h0, 0);         expect_lit("t2_c1", 2'b01, 2'b00, 1, 32'h1000, 0);
    cyc(2'b11, 1, 1, 32'h1111_0001, 0); expect_lit("t2_c2", 2'b10, 2'b01, 1, 32'h2000, 0);
    cyc(2'b11, 1, 1, 32'h1111_0002, 0); expect_lit("t2_c3", 2'b01, 2'b10, 1, 32'h1000, 0);
    cyc(2'b11, 1, 1, 32'h1111_0003, 0); expect_lit("t2_c4", 2'b10, 2'b01, 1, 32'h2000, 0);
    cyc(2'b00, 0, 1, 32'h1111_0004, 0); expect_lit("t2_c5", 2'b00, 2'b10, 0, 32'h0, 0);

    // 3: stalled master 0 keeps the port although the pointer favours master 1
    cyc(2'b01, 1, 0, 32'h0, 0); expect_lit("t3_pre",     2'b01, 2'b00, 1, 32'h1000, 0);
    cyc(2'b00, 0, 1, 32'h0, 0); expect_lit("t3_pre_rsp", 2'b00, 2'b01, 0, 32'h0, 0);
    cyc(2'b01, 0, 0, 32'h0, 0); expect_lit("t3_c1", 2'b00, 2'b00, 1, 32'h1000, 0);
    cyc(2'b11, 0, 0, 32'h0, 0); expect_lit("t3_c2", 2'b00, 2'b00, 1, 32'h1000, 0);
    cyc(2'b11, 0, 0, 32'h0, 0); expect_lit("t3_c3", 2'b00, 2'b00, 1, 32'h1000, 0);
    cyc(2'b11, 1, 0, 32'h0, 0); expect_lit("t3_c4", 2'b01, 2'b00, 1, 32'h1000, 0);
    cyc(2'b10, 1, 0, 32'h0, 0); expect_lit("t3_c5", 2'b10, 2'b00, 1, 32'h2000, 0);
    cyc(2'b00, 0, 1, 32'h0, 0); expect_lit("t3_r0", 2'b00, 2'b01, 0, 32'h0, 0);
    cyc(2'b00, 0, 1, 32'h0, 0); expect_lit("t3_r1", 2'b00, 2'b10, 0, 32'h0, 0);

    // 4: four outstanding grants fill the ID FIFO; no pop bypass while full
    for (int i = 0; i < 4; i++) begin
      cyc(2'b01, 1, 0, 32'h0, 0); expect_lit("t4_fill", 2'b01, 2'b00, 1, 32'h1000, 0);
    end
    cyc(2'b01, 1, 0, 32'h0, 0); expect_lit("t4_full",     2'b00, 2'b00, 0, 32'h1000, 0);
    cyc(2'b01, 1, 1, 32'h0, 0); expect_lit("t4_full_pop", 2'b00, 2'b01, 0, 32'h1000, 0);
    cyc(2'b01, 1, 0, 32'h0, 0); expect_lit("t4_reopen",   2'b01, 2'b00, 1, 32'h1000, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(2'b00, 0, 1, 32'h4000 + 32'(i), 0); expect_lit("t4_drain", 2'b00, 2'b01, 0, 32'h0, 0);
    end

    // 5: interleaved writes, error flagged on the second response only
    do_reset();
    bus.s_addr  = {32'h0020_1004, 32'h0020_1000};
    bus.s_we    = 2'b11;
    bus.s_wdata = {32'h5a5a_1111, 32'ha5a5_0000};
    bus.s_be    = {4'h3, 4'hf};
    cyc(2'b11, 1, 0, 32'h0, 0); expect_lit("t5_g0", 2'b01, 2'b00, 1, 32'h0020_1000, 0);
    cyc(2'b11, 1, 0, 32'h0, 0); expect_lit("t5_g1", 2'b10, 2'b00, 1, 32'h0020_1004, 0);
    cyc(2'b01, 1, 0, 32'h0, 0);
    bus.s_addr[31:0] = 32'h0020_1008;
    expect_lit("t5_g2", 2'b01, 2'b00, 1, 32'h0020_1008, 0);
    cyc(2'b00, 0, 1, 32'h0, 0); expect_lit("t5_r0", 2'b00, 2'b01, 0, 32'h0, 0);
    cyc(2'b00, 0, 1, 32'h0, 1); expect_lit("t5_r1", 2'b00, 2'b10, 0, 32'h0, 0);
    cyc(2'b00, 0, 1, 32'h0, 0); expect_lit("t5_r2", 2'b00, 2'b01, 0, 32'h0, 0);
    bus.s_we = 2'b00;

    // 6: spurious response, then reset with two transactions in flight
    cyc(2'b00, 0, 1, 32'h0000_1234, 0); expect_lit("t6_spur", 2'b00, 2'b00, 0, 32'h0, 0);
    cyc(2'b00, 0, 0, 32'h0, 0);         expect_lit("t6_perr", 2'b00, 2'b00, 0, 32'h0, 1);
    cyc(2'b01, 1, 0, 32'h0, 0); expect_lit("t6_g0", 2'b01, 2'b00, 1, 32'h0020_1008, 1);
    cyc(2'b10, 1, 0, 32'h0, 0); expect_lit("t6_g1", 2'b10, 2'b00, 1, 32'h0020_1004, 1);
    do_reset();
    cyc(2'b00, 0, 1, 32'h0000_0077, 0); expect_lit("t6_after_rst", 2'b00, 2'b00, 0, 32'h0, 0);
    cyc(2'b00, 0, 0, 32'h0, 0);         expect_lit("t6_perr2",     2'b00, 2'b00, 0, 32'h0, 1);
    cyc(2'b00, 0, 0, 32'h0, 0);

    @(negedge aclk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
